// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between I-cache and D-cache misses.
// Reads fetch a whole line of LINE_WORDS 16-bit words. D-side writes take one cycle.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN: when two requests arrive together, the
// grant alternates between the sides. Without the macro, the D side always wins.
module mem_arbiter #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_data_valid,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_data_valid,
  output logic        d_done,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        busy,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid
);

  localparam int unsigned       CNT_W    = $clog2(LINE_WORDS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_recv_cnt;
  logic [15:0]      r_base;
  logic [15:0]      r_d_addr;
  logic [15:0]      r_d_wdata;
  logic             r_d_wr;

  logic             w_grant;
  logic             w_pick_d;
  logic             w_i_dv;
  logic             w_i_done;
  logic             w_d_dv;
  logic             w_d_done;
  logic             w_en;
  logic             w_wr;
  logic [2:0]       w_fw;
  logic [15:0]      w_fd;
  logic [15:0]      w_addr;
  logic [15:0]      w_wdata;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic r_last_d;

  // On a tie, the side that did not win last time gets the grant.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);

  // Remember which side won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  // Next-state logic and memory/strobe outputs, decoded from the current state.
  always_comb begin
    w_state_nx = r_state;
    w_grant    = 1'b0;
    w_i_dv     = 1'b0;
    w_i_done   = 1'b0;
    w_d_dv     = 1'b0;
    w_d_done   = 1'b0;
    w_en       = 1'b0;
    w_wr       = 1'b0;
    w_fw       = '0;
    w_fd       = '0;
    w_addr     = '0;
    w_wdata    = '0;
    case (r_state)
      IDLE: begin
        if (i_req | d_req) begin
          w_grant = 1'b1;
          if (w_pick_d) begin
            w_state_nx = d_wr ? WRITE : FILL_D;
          end else begin
            w_state_nx = FILL_I;
          end
        end
      end
      FILL_I, FILL_D: begin
        if (r_issue_cnt != CNT_FULL) begin
          w_en   = 1'b1;
          w_addr = r_base + 16'({r_issue_cnt, 1'b0});
        end
        if (mem_data_valid) begin
          w_fw = 3'(r_recv_cnt);
          w_fd = mem_rdata;
          if (r_state == FILL_I) begin
            w_i_dv = 1'b1;
          end else begin
            w_d_dv = 1'b1;
          end
          if (r_recv_cnt == CNT_LAST) begin
            if (r_state == FILL_I) begin
              w_i_done = 1'b1;
            end else begin
              w_d_done = 1'b1;
            end
            w_state_nx = IDLE;
          end
        end
      end
      WRITE: begin
        w_en       = 1'b1;
        w_wr       = r_d_wr;
        w_addr     = r_d_addr;
        w_wdata    = r_d_wdata;
        w_d_done   = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // While reset is asserted, every output is forced quiet.
  assign i_data_valid = w_i_dv & ~rst;
  assign i_done       = w_i_done & ~rst;
  assign d_data_valid = w_d_dv & ~rst;
  assign d_done       = w_d_done & ~rst;
  assign fill_word    = rst ? 3'h0 : w_fw;
  assign fill_data    = rst ? 16'h0 : w_fd;
  assign busy         = (r_state != IDLE) & ~rst;
  assign mem_enable   = w_en & ~rst;
  assign mem_wr       = w_wr & ~rst;
  assign mem_addr     = rst ? 16'h0 : w_addr;
  assign mem_wdata    = rst ? 16'h0 : w_wdata;

  // State register, line/request latches and the issue/receive counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
      r_d_addr    <= '0;
      r_d_wdata   <= '0;
      r_d_wr      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_grant) begin
        r_base      <= w_pick_d ? {d_addr[15:4], 4'h0} : {i_addr[15:4], 4'h0};
        r_d_wr      <= d_wr;
        r_d_addr    <= d_addr;
        r_d_wdata   <= d_wdata;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else if ((r_state == FILL_I) || (r_state == FILL_D)) begin
        if (w_en) begin
          r_issue_cnt <= r_issue_cnt + CNT_ONE;
        end
        if (mem_data_valid) begin
          r_recv_cnt <= r_recv_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized, self-checking bench for mem_arbiter.
// A fixed-latency memory model returns (addr ^ salt) + 0x0101 for every read.
// Outputs are sampled at mid-cycle and collected into per-transaction queues.
// Those queues are then compared against the line-fill and arbitration rules.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, rst;
  logic i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic i_data_valid, i_done, d_data_valid, d_done, busy;
  logic [2:0] fill_word;
  logic [15:0] fill_data;
  logic mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_valid(i_data_valid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data_valid(d_data_valid), .d_done(d_done),
    .fill_word(fill_word), .fill_data(fill_data), .busy(busy),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int n_vec, n_err, cyc, lat, n_junk;
  logic [15:0] salt;
  logic inj;
  logic last_any;
  bit pend_v[64];
  logic [15:0] pend_d[64];
  bit bz[4096];
  bit tb_last_d;

  int q_rd_cyc[$], q_wr_cyc[$], q_iv_cyc[$], q_dv_cyc[$], q_idn[$], q_ddn[$];
  logic [15:0] q_rd_addr[$], q_wr_addr[$], q_wr_data[$], q_i_data[$], q_d_data[$];
  logic [2:0] q_i_word[$], q_d_word[$];

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return (a ^ salt) + 16'h0101;
  endfunction

  task automatic clear_obs();
    q_rd_cyc.delete(); q_wr_cyc.delete(); q_iv_cyc.delete(); q_dv_cyc.delete();
    q_idn.delete(); q_ddn.delete(); q_rd_addr.delete(); q_wr_addr.delete();
    q_wr_data.delete(); q_i_data.delete(); q_d_data.delete();
    q_i_word.delete(); q_d_word.delete();
  endtask

  // One clock: apply memory response, sample at mid-cycle, advance past the edge.
  task automatic step();
    int s;
    s = cyc % 64;
    mem_data_valid = pend_v[s] | inj;
    mem_rdata = pend_v[s] ? pend_d[s] : (inj ? 16'($urandom) : 16'h0);
    pend_v[s] = 1'b0;
    #4;
    last_any = i_data_valid | i_done | d_data_valid | d_done | busy | mem_enable | mem_wr |
               (mem_addr != 16'h0) | (mem_wdata != 16'h0) | (fill_word != 3'h0) | (fill_data != 16'h0);
    bz[cyc % 4096] = busy;
    if (mem_enable && !mem_wr) begin
      pend_v[(cyc + lat) % 64] = 1'b1;
      pend_d[(cyc + lat) % 64] = mdata(mem_addr);
      q_rd_addr.push_back(mem_addr); q_rd_cyc.push_back(cyc);
    end
    if (mem_enable && mem_wr) begin
      q_wr_addr.push_back(mem_addr); q_wr_data.push_back(mem_wdata); q_wr_cyc.push_back(cyc);
    end
    if (!mem_enable && (mem_wr || mem_addr != 16'h0 || mem_wdata != 16'h0)) n_junk++;
    if (i_data_valid) begin
      q_i_word.push_back(fill_word); q_i_data.push_back(fill_data); q_iv_cyc.push_back(cyc);
    end
    if (d_data_valid) begin
      q_d_word.push_back(fill_word); q_d_data.push_back(fill_data); q_dv_cyc.push_back(cyc);
    end
    if (i_done) q_idn.push_back(cyc);
    if (d_done) q_ddn.push_back(cyc);
    @(posedge clk); #1;
    cyc++;
  endtask

  // Step until n done strobes have been seen (bounded), then two idle cycles.
  task automatic run_done(input int n, input int max_cyc);
    int c;
    c = 0;
    while ((q_idn.size() + q_ddn.size()) < n && c < max_cyc) begin
      step(); c++;
    end
    if ((q_idn.size() + q_ddn.size()) < n) begin
      n_vec++; n_err++;
      $display("FAIL timeout got %0d done strobes exp %0d", q_idn.size() + q_ddn.size(), n);
    end
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; step();
    n_vec++; if (last_any !== 1'b0) begin n_err++; $display("FAIL reset_outs got %b exp 0", last_any); end
    step();
    n_vec++; if (last_any !== 1'b0) begin n_err++; $display("FAIL reset_outs2 got %b exp 0", last_any); end
    rst = 1'b0; step();
    n_vec++; if (last_any !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got %b exp 0", last_any); end
    tb_last_d = 1'b0;
  endtask

  task automatic test_ifill();
    clear_obs(); lat = 4; salt = 16'($urandom);
    i_addr = 16'h0046; i_req = 1'b1; step(); i_req = 1'b0;
    run_done(1, 60);
    n_vec++; if (q_rd_addr.size() !== 8) begin n_err++; $display("FAIL ifill_nreads got %0d exp 8", q_rd_addr.size()); end
    for (int k = 0; k < 8 && k < q_rd_addr.size(); k++) begin
      n_vec++;
      if (q_rd_addr[k] !== 16'(16'h0040 + 2 * k) || q_rd_cyc[k] !== q_rd_cyc[0] + k) begin
        n_err++; $display("FAIL ifill_addr%0d got %h@%0d exp %h@%0d", k, q_rd_addr[k], q_rd_cyc[k], 16'(16'h0040 + 2 * k), q_rd_cyc[0] + k);
      end
    end
    n_vec++; if (q_i_word.size() !== 8) begin n_err++; $display("FAIL ifill_nwords got %0d exp 8", q_i_word.size()); end
    for (int k = 0; k < 8 && k < q_i_word.size(); k++) begin
      n_vec++;
      if (q_i_word[k] !== 3'(k) || q_i_data[k] !== mdata(16'(16'h0040 + 2 * k))) begin
        n_err++; $display("FAIL ifill_word%0d got %0d/%h exp %0d/%h", k, q_i_word[k], q_i_data[k], k, mdata(16'(16'h0040 + 2 * k)));
      end
    end
    n_vec++;
    if (q_idn.size() !== 1 || q_iv_cyc.size() !== 8 || q_idn[0] !== q_iv_cyc[7]) begin
      n_err++; $display("FAIL ifill_done got %0d strobes exp 1 with 8th word", q_idn.size());
    end
    n_vec++; if (q_dv_cyc.size() + q_ddn.size() !== 0) begin n_err++; $display("FAIL ifill_dside got %0d exp 0", q_dv_cyc.size() + q_ddn.size()); end
    if (q_idn.size() > 0) begin
      n_vec++; if (bz[(q_idn[0] + 1) % 4096] !== 1'b0) begin n_err++; $display("FAIL ifill_busy_after got 1 exp 0"); end
    end
    tb_last_d = 1'b0;
  endtask

  task automatic test_write();
    clear_obs();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF; step();
    d_req = 1'b0; d_wr = 1'b0;
    run_done(1, 10);
    n_vec++;
    if (q_wr_addr.size() !== 1 || q_wr_addr[0] !== 16'h1234 || q_wr_data[0] !== 16'hBEEF) begin
      n_err++; $display("FAIL write_bus got %0d writes exp 1 at 1234=BEEF", q_wr_addr.size());
    end
    n_vec++;
    if (q_ddn.size() !== 1 || q_wr_cyc.size() !== 1 || q_ddn[0] !== q_wr_cyc[0]) begin
      n_err++; $display("FAIL write_done got %0d strobes exp 1 in write cycle", q_ddn.size());
    end
    n_vec++; if (q_rd_addr.size() + q_dv_cyc.size() !== 0) begin n_err++; $display("FAIL write_reads got %0d exp 0", q_rd_addr.size() + q_dv_cyc.size()); end
    if (q_ddn.size() > 0) begin
      n_vec++; if (bz[(q_ddn[0] + 1) % 4096] !== 1'b0) begin n_err++; $display("FAIL write_busy_after got 1 exp 0"); end
    end
    tb_last_d = 1'b1;
  endtask

  task automatic test_conflict();
    logic [15:0] ib, db, b1, b2;
    logic first_d;
    int c, fdone;
    clear_obs(); lat = $urandom_range(1, 6); salt = 16'($urandom);
    db = 16'h2000;
    ib = {16'($urandom) & 16'hFFF0};
    if (ib == db) ib = 16'h4A50;
    first_d = RR ? ~tb_last_d : 1'b1;
    i_addr = ib | 16'h000E; d_addr = db; d_wr = 1'b0; i_req = 1'b1; d_req = 1'b1;
    step();
    if (first_d) d_req = 1'b0; else i_req = 1'b0;
    c = 0;
    while ((q_idn.size() + q_ddn.size()) < 2 && c < 120) begin
      if (q_rd_addr.size() > 8) begin i_req = 1'b0; d_req = 1'b0; end
      step(); c++;
    end
    i_req = 1'b0; d_req = 1'b0; step(); step();
    b1 = first_d ? db : ib; b2 = first_d ? ib : db;
    n_vec++; if (q_rd_addr.size() !== 16) begin n_err++; $display("FAIL conf_nreads got %0d exp 16", q_rd_addr.size()); end
    for (int k = 0; k < 16 && k < q_rd_addr.size(); k++) begin
      n_vec++;
      if (q_rd_addr[k] !== 16'((k < 8 ? b1 : b2) + 2 * (k % 8))) begin
        n_err++; $display("FAIL conf_addr%0d got %h exp %h", k, q_rd_addr[k], 16'((k < 8 ? b1 : b2) + 2 * (k % 8)));
      end
    end
    n_vec++;
    if (q_i_word.size() !== 8 || q_d_word.size() !== 8 || q_idn.size() !== 1 || q_ddn.size() !== 1) begin
      n_err++; $display("FAIL conf_counts got i%0d/d%0d words exp 8/8", q_i_word.size(), q_d_word.size());
    end
    for (int k = 0; k < 8 && k < q_d_word.size() && k < q_i_word.size(); k++) begin
      n_vec++;
      if (q_d_word[k] !== 3'(k) || q_d_data[k] !== mdata(16'(db + 2 * k)) ||
          q_i_word[k] !== 3'(k) || q_i_data[k] !== mdata(16'(ib + 2 * k))) begin
        n_err++; $display("FAIL conf_word%0d got d%h i%h exp d%h i%h", k, q_d_data[k], q_i_data[k], mdata(16'(db + 2 * k)), mdata(16'(ib + 2 * k)));
      end
    end
    if (q_idn.size() == 1 && q_ddn.size() == 1 && q_rd_cyc.size() == 16) begin
      fdone = first_d ? q_ddn[0] : q_idn[0];
      n_vec++;
      if (q_rd_cyc[8] < fdone + 2) begin
        n_err++; $display("FAIL conf_order got second issue @%0d exp >= %0d", q_rd_cyc[8], fdone + 2);
      end
    end
    tb_last_d = ~first_d;
  endtask

  task automatic test_rr_alternate();
    logic exp_d;
    logic [15:0] ib, db;
    for (int t = 0; t < 2; t++) begin
      clear_obs(); lat = $urandom_range(1, 6); salt = 16'($urandom);
      ib = 16'($urandom); db = 16'($urandom);
      exp_d = RR ? ~tb_last_d : 1'b1;
      i_addr = ib; d_addr = db; d_wr = 1'b0; i_req = 1'b1; d_req = 1'b1;
      step(); i_req = 1'b0; d_req = 1'b0;
      run_done(1, 60);
      n_vec++;
      if ((exp_d ? q_d_word.size() : q_i_word.size()) !== 8 || (exp_d ? q_iv_cyc.size() : q_dv_cyc.size()) !== 0) begin
        n_err++; $display("FAIL rr_winner%0d got i%0d/d%0d words exp %s", t, q_i_word.size(), q_d_word.size(), exp_d ? "D" : "I");
      end
      n_vec++;
      if (q_rd_addr.size() == 0 || q_rd_addr[0] !== (exp_d ? {db[15:4], 4'h0} : {ib[15:4], 4'h0})) begin
        n_err++; $display("FAIL rr_base%0d got %0d reads exp base %h", t, q_rd_addr.size(), exp_d ? {db[15:4], 4'h0} : {ib[15:4], 4'h0});
      end
      tb_last_d = exp_d;
    end
  endtask

  task automatic test_rst_abort();
    int c, nd_pre, nw, c0;
    logic [15:0] a;
    clear_obs(); lat = $urandom_range(2, 6); salt = 16'($urandom);
    i_addr = 16'($urandom); i_req = 1'b1; step(); i_req = 1'b0;
    c = 0;
    while (q_i_word.size() < 3 && c < 50) begin step(); c++; end
    rst = 1'b1; step(); rst = 1'b0;
    nd_pre = q_idn.size(); nw = q_i_word.size();
    clear_obs(); c0 = cyc;
    for (int k = 0; k < 15; k++) step();
    n_vec++; if (nd_pre !== 0 || nw > 4) begin n_err++; $display("FAIL abort_done got %0d done/%0d words exp 0/<=4", nd_pre, nw); end
    n_vec++;
    if (q_iv_cyc.size() + q_dv_cyc.size() + q_idn.size() + q_ddn.size() + q_rd_addr.size() !== 0) begin
      n_err++; $display("FAIL abort_after got %0d events exp 0", q_iv_cyc.size() + q_dv_cyc.size() + q_idn.size() + q_ddn.size() + q_rd_addr.size());
    end
    n_vec++; if (bz[c0 % 4096] !== 1'b0) begin n_err++; $display("FAIL abort_idle got busy=1 exp 0"); end
    tb_last_d = 1'b0;
    clear_obs(); a = 16'($urandom);
    d_addr = a; d_wr = 1'b0; d_req = 1'b1; step(); d_req = 1'b0;
    run_done(1, 60);
    n_vec++; if (q_d_word.size() !== 8 || q_ddn.size() !== 1) begin n_err++; $display("FAIL abort_refill got %0d words exp 8", q_d_word.size()); end
    for (int k = 0; k < 8 && k < q_d_word.size(); k++) begin
      n_vec++;
      if (q_d_word[k] !== 3'(k) || q_d_data[k] !== mdata(16'({a[15:4], 4'h0} + 2 * k))) begin
        n_err++; $display("FAIL abort_refill_word%0d got %0d/%h exp %0d", k, q_d_word[k], q_d_data[k], k);
      end
    end
    tb_last_d = 1'b1;
  endtask

  task automatic test_drop();
    int c;
    logic [15:0] a;
    clear_obs(); lat = $urandom_range(1, 6); salt = 16'($urandom); a = 16'($urandom);
    i_addr = a; i_req = 1'b1;
    c = 0;
    while (q_i_word.size() < 2 && c < 30) begin step(); c++; end
    i_req = 1'b0;
    run_done(1, 60);
    n_vec++; if (q_i_word.size() !== 8 || q_idn.size() !== 1) begin n_err++; $display("FAIL drop_count got %0d words exp 8", q_i_word.size()); end
    for (int k = 0; k < 8 && k < q_i_word.size(); k++) begin
      n_vec++;
      if (q_i_word[k] !== 3'(k) || q_i_data[k] !== mdata(16'({a[15:4], 4'h0} + 2 * k))) begin
        n_err++; $display("FAIL drop_word%0d got %0d/%h exp %0d", k, q_i_word[k], q_i_data[k], k);
      end
    end
    tb_last_d = 1'b0;
  endtask

  task automatic test_idle_valid();
    logic [15:0] a;
    clear_obs();
    inj = 1'b1; step(); step(); inj = 1'b0; step();
    n_vec++;
    if (q_iv_cyc.size() + q_dv_cyc.size() + q_idn.size() + q_ddn.size() !== 0 || bz[(cyc - 1) % 4096] !== 1'b0) begin
      n_err++; $display("FAIL idle_valid got %0d strobes exp 0", q_iv_cyc.size() + q_dv_cyc.size() + q_idn.size() + q_ddn.size());
    end
    clear_obs();
    d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = 1'b1; d_req = 1'b1; inj = 1'b1;
    step(); d_req = 1'b0; d_wr = 1'b0; step(); inj = 1'b0; step(); step();
    n_vec++;
    if (q_dv_cyc.size() !== 0 || q_ddn.size() !== 1 || q_wr_addr.size() !== 1) begin
      n_err++; $display("FAIL write_valid got %0d strobes/%0d done exp 0/1", q_dv_cyc.size(), q_ddn.size());
    end
    clear_obs(); lat = $urandom_range(1, 6); salt = 16'($urandom); a = 16'($urandom);
    d_addr = a; d_req = 1'b1; step(); d_req = 1'b0;
    run_done(1, 60);
    n_vec++; if (q_d_word.size() !== 8) begin n_err++; $display("FAIL stray_fill got %0d words exp 8", q_d_word.size()); end
    for (int k = 0; k < 8 && k < q_d_word.size(); k++) begin
      n_vec++;
      if (q_d_word[k] !== 3'(k) || q_d_data[k] !== mdata(16'({a[15:4], 4'h0} + 2 * k))) begin
        n_err++; $display("FAIL stray_word%0d got %0d/%h exp %0d", k, q_d_word[k], q_d_data[k], k);
      end
    end
    tb_last_d = 1'b1;
  endtask

  task automatic test_random();
    logic ir, dr, dw, exp_d;
    logic [15:0] ia, da, wd, base;
    logic [2:0] ow[$];
    logic [15:0] od[$];
    int ov[$], odn[$];
    int nonown;
    for (int t = 0; t < 10; t++) begin
      clear_obs(); lat = $urandom_range(1, 6); salt = 16'($urandom);
      ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!ir && !dr) dr = 1'b1;
      ia = 16'($urandom); da = 16'($urandom); wd = 16'($urandom);
      exp_d = dr && (!ir || (RR ? ~tb_last_d : 1'b1));
      i_req = ir; d_req = dr; d_wr = dw; i_addr = ia; d_addr = da; d_wdata = wd;
      step(); i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      run_done(1, 60);
      tb_last_d = exp_d;
      if (exp_d && dw) begin
        n_vec++;
        if (q_wr_addr.size() !== 1 || q_wr_addr[0] !== da || q_wr_data[0] !== wd || q_ddn.size() !== 1 || q_rd_addr.size() !== 0) begin
          n_err++; $display("FAIL rnd%0d_write got %0d writes/%0d reads exp 1 at %h=%h", t, q_wr_addr.size(), q_rd_addr.size(), da, wd);
        end
      end else begin
        base = exp_d ? {da[15:4], 4'h0} : {ia[15:4], 4'h0};
        if (exp_d) begin
          ow = q_d_word; od = q_d_data; ov = q_dv_cyc; odn = q_ddn; nonown = q_iv_cyc.size() + q_idn.size();
        end else begin
          ow = q_i_word; od = q_i_data; ov = q_iv_cyc; odn = q_idn; nonown = q_dv_cyc.size() + q_ddn.size();
        end
        n_vec++; if (q_rd_addr.size() !== 8) begin n_err++; $display("FAIL rnd%0d_nreads got %0d exp 8", t, q_rd_addr.size()); end
        for (int k = 0; k < 8 && k < q_rd_addr.size(); k++) begin
          n_vec++;
          if (q_rd_addr[k] !== 16'(base + 2 * k) || q_rd_cyc[k] !== q_rd_cyc[0] + k) begin
            n_err++; $display("FAIL rnd%0d_addr%0d got %h exp %h", t, k, q_rd_addr[k], 16'(base + 2 * k));
          end
        end
        n_vec++; if (ow.size() !== 8 || nonown !== 0) begin n_err++; $display("FAIL rnd%0d_words got %0d/%0d exp 8/0", t, ow.size(), nonown); end
        for (int k = 0; k < 8 && k < ow.size(); k++) begin
          n_vec++;
          if (ow[k] !== 3'(k) || od[k] !== mdata(16'(base + 2 * k))) begin
            n_err++; $display("FAIL rnd%0d_word%0d got %0d/%h exp %0d/%h", t, k, ow[k], od[k], k, mdata(16'(base + 2 * k)));
          end
        end
        n_vec++;
        if (odn.size() !== 1 || ov.size() == 0 || odn[0] !== ov[ov.size() - 1]) begin
          n_err++; $display("FAIL rnd%0d_done got %0d strobes exp 1 with last word", t, odn.size());
        end
      end
    end
    n_vec++; if (n_junk !== 0) begin n_err++; $display("FAIL idle_bus got %0d dirty cycles exp 0", n_junk); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; inj = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    mem_rdata = 16'h0; mem_data_valid = 1'b0;
    n_vec = 0; n_err = 0; cyc = 0; lat = 4; n_junk = 0; salt = 16'h0; tb_last_d = 1'b0;
    for (int k = 0; k < 64; k++) begin pend_v[k] = 1'b0; pend_d[k] = 16'h0; end
    @(posedge clk); #1;
    test_reset();
    test_ifill();
    test_write();
    test_conflict();
    test_rr_alternate();
    test_rst_abort();
    test_drop();
    test_idle_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
